// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-stage state encoding and constants
package pc_fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} fetch_state_t;
   localparam int unsigned PC_INCR = 4;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc_plus4} park for a fetch that decode could not take
module fetch_skid_buf #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              unload_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [ADDR_W-1:0] pc_plus4_i,
   output logic              full_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] pc_plus4_o
);
   logic              full_q;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] pc_plus4_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= 1'b0;
         instr_q    <= '0;
         pc_plus4_q <= '0;
      end else begin
         full_q <= !clear_i && (load_i || (full_q && !unload_i));
         if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
         end
      end
   end
   assign full_o     = full_q;
   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner, imem req/ready fetch and IF/ID register with stall skid and redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_redirects counters.
module pc_fetch_unit
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              id_stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_redirects
`endif
);
   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q, drop_addr_q, pc_plus4, req_addr, redir_tgt, skid_pc4;
   logic [DATA_W-1:0] skid_instr;
   logic              redirect, xfer, load, unload, wr_valid, skid_full;

   assign redirect  = branch_taken | jump;
   assign redir_tgt = branch_taken ? branch_target : jump_target;
   assign pc_plus4  = pc_q + ADDR_W'(PC_INCR);
   assign imem_req  = state_q == REQ || state_q == DROP;
   // a dropped request keeps presenting its original address until it completes
   assign req_addr  = state_q == DROP ? drop_addr_q : pc_q;
   assign imem_addr = req_addr & ~ADDR_W'(3);
   assign xfer      = imem_req & imem_ready;
   assign load      = !redirect && state_q == REQ && xfer && id_stall;
   assign unload    = !redirect && state_q == HOLD && skid_full && !id_stall;
   assign wr_valid  = unload || (!redirect && state_q == REQ && xfer && !id_stall);

   fetch_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
      .clk(clk), .rst_n(rst_n), .load_i(load), .unload_i(unload), .clear_i(redirect),
      .instr_i(imem_rdata), .pc_plus4_i(pc_plus4),
      .full_o(skid_full), .instr_o(skid_instr), .pc_plus4_o(skid_pc4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         if_valid    <= 1'b0;
         if_instr    <= NOP_INSTR;
         if_pc_plus4 <= '0;
      end else if (redirect) begin
         pc_q     <= redir_tgt;
         if_valid <= 1'b0;
         if_instr <= NOP_INSTR;
         state_q  <= (imem_req && !xfer) ? DROP : REQ;
         if (state_q == REQ) drop_addr_q <= pc_q;
      end else begin
         if (state_q == REQ && xfer) pc_q <= pc_plus4;
         state_q <= state_q == IDLE ? REQ :
                    load ? HOLD :
                    (unload || (state_q == DROP && xfer)) ? REQ : state_q;
         // an unstalled decode consumes IF/ID every cycle, so no new data means a bubble
         if (wr_valid)
            {if_valid, if_instr, if_pc_plus4} <= unload ? {1'b1, skid_instr, skid_pc4}
                                                        : {1'b1, imem_rdata, pc_plus4};
         else if (!id_stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
      end else begin
         perf_fetched   <= perf_fetched + 32'(wr_valid);
         perf_redirects <= perf_redirects + 32'(redirect);
      end
   end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: transaction-level fetch model feeding a scoreboard, checked by an IF/ID monitor
module tb_pc_fetch_unit;
   typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} ent_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        branch_taken = 1'b0, jump = 1'b0, id_stall = 1'b0, imem_ready = 1'b0;
   logic [31:0] branch_target = '0, jump_target = '0, junk = '0;
   logic        imem_req, if_valid;
   logic [31:0] imem_addr, imem_rdata, if_instr, if_pc_plus4;

   int   n_cmp = 0, n_bad = 0;
   ent_t exp_q[$];
   logic [31:0] m_pc = '0, m_drop_addr = '0;
   bit   m_drop = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .id_stall(id_stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : junk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit st, input bit rd, input bit br, input bit jp,
                       input logic [31:0] bt, input logic [31:0] jt);
      id_stall = st; imem_ready = rd; branch_taken = br; jump = jp;
      branch_target = bt; jump_target = jt; junk = $urandom;
      @(posedge clk); #1;
   endtask

   // reference model: tracks the next useful fetch address, an abandoned request, and fetched-but-unconsumed words
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         m_pc = '0; m_drop = 1'b0; exp_q.delete();
      end else begin
         if (imem_req) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : (m_pc & ~32'h3));
         if (exp_q.size() >= 2) chk("req_while_parked", {31'b0, imem_req}, 32'd0);
         if (branch_taken || jump) begin
            exp_q.delete();
            if (imem_req && !imem_ready && !m_drop) begin
               m_drop = 1'b1; m_drop_addr = m_pc & ~32'h3;
            end else if (imem_req && imem_ready) m_drop = 1'b0;
            m_pc = branch_taken ? branch_target : jump_target;
         end else if (imem_req && imem_ready) begin
            if (m_drop) m_drop = 1'b0;
            else begin
               exp_q.push_back('{mem_word(m_pc & ~32'h3), m_pc + 32'd4});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   // monitor: decode consumes IF/ID whenever it is valid, not stalled and not being flushed
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() == 0) chk("if_valid_empty", {31'b0, if_valid}, 32'd0);
         if (if_valid && !id_stall && !(branch_taken || jump)) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL if_extra: got instr %h with nothing expected at %0t", if_instr, $time);
            end else begin
               ent_t e;
               e = exp_q.pop_front();
               chk("if_instr", if_instr, e.instr);
               chk("if_pc_plus4", if_pc_plus4, e.pc4);
            end
         end
      end
   end

   initial begin
      logic [31:0] t1, t2;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc4", if_pc_plus4, 32'h0);
      rst_n = 1'b1;
      #1 chk("idle_req", {31'b0, imem_req}, 32'd0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0, 0, 0);
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 32'h40, 0);
      chk("flush_valid", {31'b0, if_valid}, 32'd0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 32'h80, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("after_drop_addr", imem_addr, 32'h80);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 32'h100, 32'h200);
      chk("branch_wins", imem_addr, 32'h100);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0, 0);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc4", if_pc_plus4, 32'h0);
      step(0, 0, 1, 0, 32'h300, 0);
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("async_req", {31'b0, imem_req}, 32'd0);
      chk("async_valid", {31'b0, if_valid}, 32'd0);
      chk("async_instr", if_instr, 32'h0);
      chk("async_pc4", if_pc_plus4, 32'h0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         t1 = $urandom; t2 = $urandom;
         if ($urandom_range(0, 3) != 0) begin t1[1:0] = 2'b00; t2[1:0] = 2'b00; end
         if ($urandom_range(0, 7) == 0) t1[31:6] = '1;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, t1, t2);
      end
      @(negedge clk); #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
